mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported instruction/data memory between the fetch stage (IF) and the
//  load/store stage (DM) of the pipelined core. It grants one requester at a time and
//  sequences a multi-cycle memory access with a latency counter. It returns read data with
//  a one-cycle ready pulse and provides stall signals to the pipeline hazard logic.
// PARAMETERS
//  DATA_WIDTH   32  memory word width
//  ADDR_WIDTH   32  byte address width
//  MEM_LATENCY  2   cycles mem_en is held per access (legal range 1..15)
// PORTS
//  clk        in   1           system clock, rising edge
//  rst        in   1           asynchronous, active-high reset
//  if_req     in   1           fetch read request; held with stable if_addr until if_ready
//  if_addr    in   ADDR_WIDTH  fetch address
//  if_rdata   out  DATA_WIDTH  fetched instruction (registered)
//  if_ready   out  1           one-cycle pulse: if_rdata valid for current request
//  if_stall   out  1           if_req & ~if_ready (combinational)
//  dm_req     in   1           data request; held with stable addr/we/wdata until dm_ready
//  dm_we      in   1           1 = store, 0 = load
//  dm_addr    in   ADDR_WIDTH  data address
//  dm_wdata   in   DATA_WIDTH  store data
//  dm_rdata   out  DATA_WIDTH  load result (registered)
//  dm_ready   out  1           one-cycle pulse: access complete
//  dm_stall   out  1           dm_req & ~dm_ready (combinational)
//  mem_en     out  1           memory access enable
//  mem_we     out  1           memory write enable
//  mem_addr   out  ADDR_WIDTH  memory address
//  mem_wdata  out  DATA_WIDTH  memory write data
//  mem_rdata  in   DATA_WIDTH  memory read data, valid in the last ACCESS cycle
// BEHAVIOUR
//  - FSM states are IDLE, ACCESS and DONE; the state is IDLE after reset.
//  - IDLE: a req high at a clock edge is a new request.
//      - Grant DM if dm_req. Otherwise grant IF if if_req.
//      - Exception: if starve_cnt==2 and if_req is high, grant IF.
//      - On grant, latch owner, addr, we (0 for IF) and wdata. Load cnt=MEM_LATENCY-1 and go to ACCESS.
//  - starve_cnt (2-bit) tracks DM grants that skip a waiting IF:
//      - On a DM grant with if_req high, increment starve_cnt.
//      - On a DM grant with if_req low, clear starve_cnt to 0.
//      - On any IF grant, clear starve_cnt to 0.
//  - ACCESS: mem_en=1. mem_we, mem_addr and mem_wdata are driven from the latched registers and are stable for all MEM_LATENCY cycles.
//      - If cnt!=0, decrement cnt.
//      - If cnt==0 and the access is a read, capture mem_rdata into the owner's rdata register. Then go to DONE.
//  - DONE: mem_en=0. The owner's ready is 1 for exactly this cycle. Next state is IDLE.
//  - Latency: with req sampled at edge E0, ready is high in cycle MEM_LATENCY+1 after E0.
//    One access completes every MEM_LATENCY+2 cycles.
//  - Stores: dm_rdata keeps its previous value. dm_ready pulses as for loads.
//  - Each rdata register holds its value until the next read completion by the same owner.
//  - Requests are sampled only in IDLE. A req that rises during ACCESS or DONE waits.
//  - Requester drops req mid-access: the access runs to completion and ready still pulses.
//  - Outputs are glitch-free decodes of state, plus registers. In IDLE and DONE: mem_en=0, mem_we=0.
//  - Reset (async, any state, including mid-ACCESS) takes effect immediately:
//      - State goes to IDLE; cnt=0, starve_cnt=0, owner=IF.
//      - Latched addr/wdata registers, if_rdata and dm_rdata are all 0.
//      - mem_en, mem_we, if_ready and dm_ready are 0; mem_addr and mem_wdata are 0.
//  - cnt width is 4 bits; MEM_LATENCY outside 1..15 is a configuration error (elaboration assertion).
// TESTING
//  1. Assert rst in the 2nd ACCESS cycle of a DM store -> mem_en, mem_we and dm_ready are 0 in the same cycle.
//     After reset: rdata=0; a subsequent if_req is granted normally.
//  2. MEM_LATENCY=2; if_req with if_addr=0x0000_0004 and mem_rdata=0x0050_0093.
//     -> mem_en is high for 2 cycles with mem_addr=0x4.
//     -> if_ready pulses in cycle 3 after the sampling edge, with if_rdata=0x0050_0093.
//  3. if_req and dm_req (load, 0x100) rise together -> DM is served first.
//     if_stall stays high until IF is served; IF is granted in the IDLE cycle after dm_ready.
//  4. DM store with dm_addr=0x10 and dm_wdata=0xDEAD_BEEF.
//     -> mem_en=1, mem_we=1, mem_addr=0x10, mem_wdata=0xDEAD_BEEF for 2 cycles.
//     -> dm_ready pulses once; dm_rdata is unchanged.
//  5. dm_req and if_req both held high continuously -> grant order is DM, DM, IF, DM, DM, IF.
//     No request is starved.
//  6. MEM_LATENCY=1; if_req drops during ACCESS -> the access completes and if_ready pulses.
//     The next access is granted only when a req is high in IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between the fetch (IF) and load/store (DM) stages.
// DM has priority, and IF is forced in after two consecutive DM grants that skipped a waiting fetch.

module mem_port_arbiter_cfg_chk #(
  parameter int MEM_LATENCY = 2
) ();
  if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
    $error("mem_port_arbiter: MEM_LATENCY must be within 1..15");
  end
endmodule

module mem_port_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_ready,
  output logic                  if_stall,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  dm_ready,
  output logic                  dm_stall,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic       OWN_IF   = 1'b0;
  localparam logic       OWN_DM   = 1'b1;
  localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

  mem_port_arbiter_cfg_chk #(.MEM_LATENCY(MEM_LATENCY)) u_cfg_chk ();

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [1:0]            starve_q, starve_d;
  logic                  owner_q, owner_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
  logic                  grant_if_s;

  // IF wins only when DM is idle or IF has already been skipped twice
  assign grant_if_s = if_req && (!dm_req || (starve_q == 2'd2));

  // Next-state, grant latching and read-data capture
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    starve_d   = starve_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_if_s) begin
          owner_d  = OWN_IF;
          we_d     = 1'b0;
          addr_d   = if_addr;
          wdata_d  = '0;
          starve_d = 2'd0;
          cnt_d    = CNT_LOAD;
          state_d  = ACCESS;
        end else if (dm_req) begin
          owner_d  = OWN_DM;
          we_d     = dm_we;
          addr_d   = dm_addr;
          wdata_d  = dm_wdata;
          starve_d = if_req ? (starve_q + 2'd1) : 2'd0;
          cnt_d    = CNT_LOAD;
          state_d  = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (!we_q) begin
            if (owner_q == OWN_DM) begin
              dm_rdata_d = mem_rdata;
            end else begin
              if_rdata_d = mem_rdata;
            end
          end else begin
            dm_rdata_d = dm_rdata_q;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      starve_q   <= 2'd0;
      owner_q    <= OWN_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign mem_en    = (state_q == ACCESS);
  assign mem_we    = (state_q == ACCESS) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_ready  = (state_q == DONE) && (owner_q == OWN_IF);
  assign dm_ready  = (state_q == DONE) && (owner_q == OWN_DM);
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_stall  = if_req && !if_ready;
  assign dm_stall  = dm_req && !dm_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table plus multi-cycle sequences,
// with read results checked through an expected-result queue.

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, mem_rdata = '0;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_ready, if_stall, dm_ready, dm_stall, mem_en, mem_we;

  // second instance with single-cycle latency
  logic        if_req1 = 1'b0, dm_req1 = 1'b0, dm_we1 = 1'b0;
  logic [31:0] if_addr1 = '0, dm_addr1 = '0, dm_wdata1 = '0, mem_rdata1 = '0;
  logic [31:0] if_rdata1, dm_rdata1, mem_addr1, mem_wdata1;
  logic        if_ready1, if_stall1, dm_ready1, dm_stall1, mem_en1, mem_we1;

  int check_cnt = 0;
  int error_cnt = 0;

  typedef struct {
    logic        is_dm;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic        is_dm;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
  } vec_t;

  logic [31:0] exp_if = '0;
  logic [31:0] exp_dm = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_ready(if_ready1), .if_stall(if_stall1),
    .dm_req(dm_req1), .dm_we(dm_we1), .dm_addr(dm_addr1), .dm_wdata(dm_wdata1),
    .dm_rdata(dm_rdata1), .dm_ready(dm_ready1), .dm_stall(dm_stall1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act !== exp) begin
      error_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: every ready pulse must match the oldest outstanding expectation
  always @(negedge clk) begin : sb_mon
    exp_t e;
    if (!rst && (if_ready || dm_ready)) begin
      if (sb_q.size() == 0) begin
        chk("sb_spurious_ready", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_owner", {31'd0, dm_ready}, {31'd0, e.is_dm});
        chk("sb_both_ready", {31'd0, if_ready && dm_ready}, 32'd0);
        chk("sb_rdata", e.is_dm ? dm_rdata : if_rdata, e.rdata);
      end
    end
  end

  // single transaction on the latency-2 instance; caller enters just after an edge in IDLE
  task automatic run_vec(input vec_t v);
    if (v.is_dm) begin
      dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata;
      if (!v.we) exp_dm = v.rd;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
      exp_if = v.rd;
    end
    sb_q.push_back('{is_dm: v.is_dm, rdata: (v.is_dm ? exp_dm : exp_if)});
    mem_rdata = 32'hBAD0_0000;
    @(posedge clk);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c <= 2) begin
        chk("vec_mem_en", {31'd0, mem_en}, 32'd1);
        chk("vec_mem_we", {31'd0, mem_we}, {31'd0, v.is_dm & v.we});
        chk("vec_mem_addr", mem_addr, v.addr);
        if (v.is_dm) chk("vec_mem_wdata", mem_wdata, v.wdata);
        chk("vec_ready_early", {30'd0, if_ready, dm_ready}, 32'd0);
        chk("vec_stall", {30'd0, if_stall, dm_stall}, v.is_dm ? 32'd1 : 32'd2);
      end else begin
        chk("vec_done_mem_en", {30'd0, mem_en, mem_we}, 32'd0);
        chk("vec_done_ready", {30'd0, if_ready, dm_ready}, v.is_dm ? 32'd1 : 32'd2);
        chk("vec_done_stall", {30'd0, if_stall, dm_stall}, 32'd0);
      end
      mem_rdata = (c == 2) ? v.rd : (32'hBAD0_0000 | 32'(c));
    end
    @(posedge clk); #1;
    if_req = 1'b0; dm_req = 1'b0;
  endtask

  // n back-to-back grants of 4 cycles each; own[k]=1 means DM expected for grant k
  task automatic run_grants(input int n, input logic [7:0] own, input bit drop_dm, input logic [31:0] base);
    for (int k = 0; k < n; k++) begin
      sb_q.push_back('{is_dm: own[k], rdata: base + 32'(k)});
    end
    mem_rdata = 32'hBAD1_0000;
    @(posedge clk);
    for (int c = 1; c <= 4 * n; c++) begin
      int k, ph;
      logic rdy_if, rdy_dm;
      @(negedge clk);
      k = (c - 1) / 4;
      ph = (c - 1) % 4;
      rdy_if = (ph == 2) && !own[k];
      rdy_dm = (ph == 2) && own[k];
      chk("gr_mem_en", {31'd0, mem_en}, (ph < 2) ? 32'd1 : 32'd0);
      chk("gr_mem_we", {31'd0, mem_we}, 32'd0);
      if (ph < 2) chk("gr_mem_addr", mem_addr, own[k] ? dm_addr : if_addr);
      chk("gr_if_ready", {31'd0, if_ready}, {31'd0, rdy_if});
      chk("gr_dm_ready", {31'd0, dm_ready}, {31'd0, rdy_dm});
      chk("gr_if_stall", {31'd0, if_stall}, {31'd0, if_req && !rdy_if});
      chk("gr_dm_stall", {31'd0, dm_stall}, {31'd0, dm_req && !rdy_dm});
      mem_rdata = (ph == 1) ? (base + 32'(k)) : (32'hBAD1_0000 | 32'(c));
      if (drop_dm && k == 0 && ph == 2) dm_req = 1'b0;
      if (c == 4 * n) begin
        if_req = 1'b0; dm_req = 1'b0;
      end
    end
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{is_dm: 1'b0, we: 1'b0, addr: 32'h0000_0004, wdata: 32'h0, rd: 32'h0050_0093};
    vecs[1] = '{is_dm: 1'b1, we: 1'b0, addr: 32'h0000_0100, wdata: 32'h0, rd: 32'h1234_5678};
    vecs[2] = '{is_dm: 1'b1, we: 1'b1, addr: 32'h0000_0010, wdata: 32'hDEAD_BEEF, rd: 32'h5555_AAAA};
    vecs[3] = '{is_dm: 1'b0, we: 1'b0, addr: 32'h0000_0008, wdata: 32'h0, rd: 32'hCAFE_F00D};
    vecs[4] = '{is_dm: 1'b1, we: 1'b0, addr: 32'hFFFF_FFFC, wdata: 32'h0, rd: 32'hFFFF_FFFF};
    vecs[5] = '{is_dm: 1'b0, we: 1'b0, addr: 32'h0000_0000, wdata: 32'h0, rd: 32'h0000_0000};

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_en_we", {30'd0, mem_en, mem_we}, 32'd0);
    chk("rst_ready", {30'd0, if_ready, dm_ready}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_dm_rdata", dm_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_l1_mem_en", {31'd0, mem_en1}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);
    chk("store_keeps_dm_rdata", dm_rdata, 32'hFFFF_FFFF);

    // simultaneous IF and DM load: DM first, IF in the IDLE after dm_ready
    dm_we = 1'b0; dm_addr = 32'h0000_0100; if_addr = 32'h0000_0040;
    if_req = 1'b1; dm_req = 1'b1;
    run_grants(2, 8'b0000_0001, 1'b1, 32'h3000_0000);

    // both requests held: DM, DM, IF, DM, DM, IF
    @(posedge clk); #1;
    dm_we = 1'b0; dm_addr = 32'h0000_0200; if_addr = 32'h0000_0300;
    if_req = 1'b1; dm_req = 1'b1;
    run_grants(6, 8'b0001_1011, 1'b0, 32'h5000_0000);

    // async reset in the 2nd ACCESS cycle of a store
    @(posedge clk); #1;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0010; dm_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_pre_en", {31'd0, mem_en}, 32'd1);
    @(posedge clk); #2;
    chk("rst_mid_pre_we", {31'd0, mem_we}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_mem_en_we", {30'd0, mem_en, mem_we}, 32'd0);
    chk("rst_mid_dm_ready", {31'd0, dm_ready}, 32'd0);
    chk("rst_mid_mem_addr", mem_addr, 32'd0);
    chk("rst_mid_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mid_if_rdata", if_rdata, 32'd0);
    chk("rst_mid_dm_rdata", dm_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    exp_if = '0; exp_dm = '0;
    @(posedge clk); #1;
    run_vec('{is_dm: 1'b0, we: 1'b0, addr: 32'h0000_0020, wdata: 32'h0, rd: 32'h1357_9BDF});

    // latency 1: IF drops req during ACCESS, access still completes
    @(posedge clk); #1;
    if_req1 = 1'b1; if_addr1 = 32'h0000_0044; mem_rdata1 = 32'hBAD2_0000;
    @(posedge clk);
    @(negedge clk);
    chk("l1_mem_en", {31'd0, mem_en1}, 32'd1);
    chk("l1_mem_addr", mem_addr1, 32'h0000_0044);
    mem_rdata1 = 32'h600D_CAFE;
    if_req1 = 1'b0;
    @(negedge clk);
    mem_rdata1 = 32'hBAD2_0001;
    chk("l1_if_ready", {31'd0, if_ready1}, 32'd1);
    chk("l1_if_rdata", if_rdata1, 32'h600D_CAFE);
    chk("l1_done_mem_en", {31'd0, mem_en1}, 32'd0);
    chk("l1_if_stall", {31'd0, if_stall1}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("l1_no_req_idle", {30'd0, mem_en1, if_ready1}, 32'd0);
    end
    if_req1 = 1'b1; if_addr1 = 32'h0000_0048;
    @(negedge clk);
    chk("l1_regrant_en", {31'd0, mem_en1}, 32'd1);
    chk("l1_regrant_addr", mem_addr1, 32'h0000_0048);
    chk("l1_regrant_stall", {31'd0, if_stall1}, 32'd1);
    if_req1 = 1'b0;
    @(negedge clk);
    chk("l1_regrant_ready", {31'd0, if_ready1}, 32'd1);
    chk("l1_regrant_rdata", if_rdata1, 32'hBAD2_0001);

    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", error_cnt, check_cnt);
    $finish;
  end

endmodule
